// File: rtl/exec_sequencer.sv
// Multi-cycle core control FSM: fetch, decode, execute, memory, writeback, sticky trap.
// Latency: 4 cycles FETCH..WRITEBACK for alu/branch/jump, 5 for load/store, +1 per ack wait cycle.
// Backpressure: stalls in FETCH/MEMORY until imem_ack_i/dmem_ack_i; watchdog traps after TIMEOUT waits.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   run_i                    core enable, sampled in IDLE and WRITEBACK
//   imem_req_o / imem_ack_i  instruction fetch handshake
//   dec_en_o                 decode latch strobe; is_*_i class flags valid while it is high
//   ex_en_o                  execute strobe
//   dmem_req_o, dmem_we_o / dmem_ack_i  data access handshake (we=1 store)
//   rf_we_o, pc_we_o         writeback strobes
//   trap_o, state_o, retired_o  sticky error, debug state, retired-instruction count
module exec_sequencer #(
  parameter int RETIRE_W = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                run_i,
  output logic                imem_req_o,
  input  logic                imem_ack_i,
  output logic                dec_en_o,
  input  logic                is_load_i,
  input  logic                is_store_i,
  input  logic                is_branch_i,
  input  logic                is_jump_i,
  input  logic                is_alu_i,
  input  logic                is_reg_i,
  input  logic                is_illegal_i,
  output logic                ex_en_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  input  logic                dmem_ack_i,
  output logic                rf_we_o,
  output logic                pc_we_o,
  output logic                trap_o,
  output logic [2:0]          state_o,
  output logic [RETIRE_W-1:0] retired_o
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Latched class bit positions: {load, store, branch, jump, alu}
  localparam int C_LD = 4;
  localparam int C_ST = 3;
  localparam int C_JP = 1;
  localparam int C_AL = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEMORY  = 3'd4,
    S_WB      = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          class_q, class_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic imem_req_q, dec_en_q, ex_en_q, dmem_req_q, dmem_we_q, rf_we_q, pc_we_q, trap_q;

  logic [4:0] dec_class;
  logic       watchdog_expired;

  // is_reg only qualifies the ALU operand inside execute; sequencing does not depend on it.
  logic unused_is_reg;
  assign unused_is_reg = is_reg_i;

  assign dec_class        = {is_load_i, is_store_i, is_branch_i, is_jump_i, is_alu_i};
  assign watchdog_expired = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        // An ack on the final allowed wait cycle still wins over the watchdog.
        if (imem_ack_i) begin
          state_d = S_DECODE;
        end else if (watchdog_expired) begin
          state_d = S_TRAP;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (is_illegal_i || ($countones(dec_class) != 1)) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (class_q[C_LD] || class_q[C_ST]) begin
          state_d = S_MEMORY;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEMORY: begin
        if (dmem_ack_i) begin
          state_d = S_WB;
        end else if (watchdog_expired) begin
          state_d = S_TRAP;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        retired_d = retired_q + RETIRE_W'(1);
        if (run_i) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Outputs are registered from the next state so each strobe is a pure
  // function of the state register once it lands; no input reaches an output
  // within the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      class_q    <= '0;
      wait_q     <= '0;
      retired_q  <= '0;
      imem_req_q <= 1'b0;
      dec_en_q   <= 1'b0;
      ex_en_q    <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      imem_req_q <= (state_d == S_FETCH);
      dec_en_q   <= (state_d == S_DECODE);
      ex_en_q    <= (state_d == S_EXECUTE);
      dmem_req_q <= (state_d == S_MEMORY);
      dmem_we_q  <= (state_d == S_MEMORY) && class_d[C_ST];
      rf_we_q    <= (state_d == S_WB) && (class_d[C_LD] || class_d[C_JP] || class_d[C_AL]);
      pc_we_q    <= (state_d == S_WB);
      trap_q     <= (state_d == S_TRAP);
    end
  end

  assign imem_req_o = imem_req_q;
  assign dec_en_o   = dec_en_q;
  assign ex_en_o    = ex_en_q;
  assign dmem_req_o = dmem_req_q;
  assign dmem_we_o  = dmem_we_q;
  assign rf_we_o    = rf_we_q;
  assign pc_we_o    = pc_we_q;
  assign trap_o     = trap_q;
  assign state_o    = state_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: per-instruction timelines expand into a per-cycle
// queue of stimulus plus expected outputs, which is replayed against the DUT.
module tb_exec_sequencer;

  localparam int RW = 4;
  localparam int TO = 15;

  // Class vector order {load, store, branch, jump, alu}
  localparam logic [4:0] C_LOAD   = 5'b10000;
  localparam logic [4:0] C_STORE  = 5'b01000;
  localparam logic [4:0] C_BRANCH = 5'b00100;
  localparam logic [4:0] C_JUMP   = 5'b00010;
  localparam logic [4:0] C_ALU    = 5'b00001;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_TRAP = 6;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          run_i = 1'b0, imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
  logic          is_load_i = 1'b0, is_store_i = 1'b0, is_branch_i = 1'b0, is_jump_i = 1'b0;
  logic          is_alu_i = 1'b0, is_reg_i = 1'b0, is_illegal_i = 1'b0;
  logic          imem_req_o, dec_en_o, ex_en_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, trap_o;
  logic [2:0]    state_o;
  logic [RW-1:0] retired_o;

  exec_sequencer #(.RETIRE_W(RW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .dec_en_o(dec_en_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i), .is_branch_i(is_branch_i),
    .is_jump_i(is_jump_i), .is_alu_i(is_alu_i), .is_reg_i(is_reg_i), .is_illegal_i(is_illegal_i),
    .ex_en_o(ex_en_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .rf_we_o(rf_we_o), .pc_we_o(pc_we_o), .trap_o(trap_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [14:0] exp;
    logic        run, iack, dack, rg, ill;
    logic [4:0]  fl;
  } ent_t;

  ent_t          q[$];
  logic [RW-1:0] m_ret = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic [4:0] r5();
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [14:0] dut_vec();
    return {state_o, imem_req_o, dec_en_o, ex_en_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, trap_o, retired_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle spent in phase ph; outputs follow from the phase and the instruction class.
  task automatic push(input int ph, input logic [4:0] lc, input logic run_v, input logic iack,
                      input logic dack, input logic [4:0] fl, input logic ill);
    ent_t e;
    logic writes_rf;
    writes_rf = lc[4] | lc[1] | lc[0];
    e.exp = {3'(ph), ph == P_FETCH, ph == P_DECODE, ph == P_EXEC, ph == P_MEM,
             (ph == P_MEM) && lc[3], (ph == P_WB) && writes_rf, ph == P_WB, ph == P_TRAP, m_ret};
    e.run = run_v; e.iack = iack; e.dack = dack; e.fl = fl; e.ill = ill; e.rg = rb();
    q.push_back(e);
  endtask

  task automatic push_idle(input int n, input logic last_run);
    for (int i = 0; i < n; i++) push(P_IDLE, 5'b0, (i == n - 1) ? last_run : 1'b0, rb(), rb(), r5(), rb());
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(P_TRAP, 5'b0, rb(), rb(), rb(), r5(), rb());
  endtask

  // ia/da: wait cycles before the ack; beyond TO the ack never comes and the watchdog fires.
  task automatic push_instr(input logic [4:0] fl, input logic ill, input int ia, input int da,
                            input logic run_wb, output logic trapped);
    trapped = 1'b0;
    if (ia > TO) begin
      for (int w = 0; w <= TO; w++) push(P_FETCH, 5'b0, rb(), 1'b0, rb(), r5(), rb());
      trapped = 1'b1;
    end else begin
      for (int w = 0; w < ia; w++) push(P_FETCH, 5'b0, rb(), 1'b0, rb(), r5(), rb());
      push(P_FETCH, 5'b0, rb(), 1'b1, rb(), r5(), rb());
      push(P_DECODE, 5'b0, rb(), rb(), rb(), fl, ill);
      if (ill || ($countones(fl) != 1)) begin
        trapped = 1'b1;
      end else begin
        push(P_EXEC, fl, rb(), rb(), rb(), r5(), rb());
        if (fl[4] || fl[3]) begin
          if (da > TO) begin
            for (int w = 0; w <= TO; w++) push(P_MEM, fl, rb(), rb(), 1'b0, r5(), rb());
            trapped = 1'b1;
          end else begin
            for (int w = 0; w < da; w++) push(P_MEM, fl, rb(), rb(), 1'b0, r5(), rb());
            push(P_MEM, fl, rb(), rb(), 1'b1, r5(), rb());
          end
        end
        if (!trapped) begin
          push(P_WB, fl, run_wb, rb(), rb(), r5(), rb());
          m_ret = m_ret + 1'b1;
        end
      end
    end
  endtask

  // Entered at posedge+1: check the current cycle's outputs, drive its inputs, advance.
  task automatic run_queue();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("cycle", 32'(dut_vec()), 32'(e.exp));
      run_i = e.run; imem_ack_i = e.iack; dmem_ack_i = e.dack;
      {is_load_i, is_store_i, is_branch_i, is_jump_i, is_alu_i} = e.fl;
      is_reg_i = e.rg; is_illegal_i = e.ill;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic do_reset(input string nm);
    #2;
    rst_ni = 1'b0;
    run_i = 1'b0; imem_ack_i = 1'b1; dmem_ack_i = 1'b1;
    #1;
    chk(nm, 32'(dut_vec()), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    m_ret = '0;
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic          tr;
    logic [RW-1:0] save;
    int            r;
    logic [4:0]    fl;
    logic          ill, run_wb, in_idle;

    #3;
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Pin the model's cycle counts against hand-derived numbers.
    save = m_ret;
    push_instr(C_ALU, 1'b0, 0, 0, 1'b0, tr);
    chk("model_alu_len", q.size(), 4);
    q.delete();
    push_instr(C_LOAD, 1'b0, 0, 3, 1'b0, tr);
    chk("model_load_len", q.size(), 8);
    q.delete();
    push_instr(C_ALU, 1'b0, 16, 0, 1'b0, tr);
    chk("model_wd_len", q.size(), 16);
    q.delete();
    m_ret = save;

    // ALU, immediate acks
    push_idle(2, 1'b1);
    push_instr(C_ALU, 1'b0, 0, 0, 1'b0, tr);
    push_idle(1, 1'b0);
    run_queue();
    chk("alu_retired", 32'(retired_o), 32'd1);

    // Load with 3 dmem wait cycles, then back-to-back store
    push_idle(1, 1'b1);
    push_instr(C_LOAD, 1'b0, 0, 3, 1'b1, tr);
    push_instr(C_STORE, 1'b0, 1, 2, 1'b0, tr);
    push_idle(1, 1'b0);
    // Branch, run dropped mid-instruction and at WB
    push_idle(1, 1'b1);
    push_instr(C_BRANCH, 1'b0, 0, 0, 1'b0, tr);
    push_idle(3, 1'b0);
    run_queue();
    chk("after_branch_state", 32'(state_o), 32'd0);
    chk("after_branch_retired", 32'(retired_o), 32'd4);

    // Reset in the middle of a fetch wait
    push_idle(1, 1'b1);
    push(P_FETCH, 5'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
    push(P_FETCH, 5'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
    run_queue();
    chk("midfetch_req", 32'(imem_req_o), 32'd1);
    do_reset("reset_midfetch");
    push_idle(4, 1'b0);
    run_queue();

    // Illegal encoding
    push_idle(1, 1'b1);
    push_instr(C_ALU, 1'b1, 0, 0, 1'b1, tr);
    push_trap(4);
    run_queue();
    chk("illegal_trap", 32'(trap_o), 32'd1);
    do_reset("reset_after_illegal");
    // Multi-hot class
    push_idle(1, 1'b1);
    push_instr(C_LOAD | C_ALU, 1'b0, 0, 0, 1'b1, tr);
    push_trap(3);
    run_queue();
    do_reset("reset_after_multihot");

    // Watchdog: ack on the last allowed wait cycle, then no ack at all
    push_idle(1, 1'b1);
    push_instr(C_JUMP, 1'b0, 15, 0, 1'b1, tr);
    push_instr(C_STORE, 1'b0, 0, 15, 1'b1, tr);
    push_instr(C_ALU, 1'b0, 16, 0, 1'b1, tr);
    push_trap(3);
    run_queue();
    chk("watchdog_trap", 32'(trap_o), 32'd1);
    chk("watchdog_retired", 32'(retired_o), 32'd2);
    do_reset("reset_after_wd");
    push_idle(1, 1'b1);
    push_instr(C_LOAD, 1'b0, 2, 16, 1'b1, tr);
    push_trap(2);
    run_queue();
    do_reset("reset_after_dwd");

    // Counter wrap: 16 instructions on a 4-bit counter
    push_idle(1, 1'b1);
    for (int i = 0; i < 16; i++) push_instr(C_ALU, 1'b0, 0, 0, (i != 15), tr);
    push_idle(2, 1'b0);
    run_queue();
    chk("retired_wrap", 32'(retired_o), 32'd0);

    // Randomized instruction stream
    in_idle = 1'b1;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      ill = (r == 19);
      if (r < 18) fl = 5'b1 << (r % 5);
      else        fl = r5();
      run_wb = ($urandom_range(0, 3) != 0);
      if (in_idle) push_idle($urandom_range(1, 3), 1'b1);
      push_instr(fl, ill,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3),
                 run_wb, tr);
      if (tr) begin
        push_trap($urandom_range(1, 3));
        run_queue();
        do_reset("reset_random");
        in_idle = 1'b1;
      end else begin
        run_queue();
        in_idle = !run_wb;
      end
    end
    if (!in_idle) begin
      push(P_FETCH, 5'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
      run_queue();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
